// File: rtl/rvx_lsu.sv
// rvx_lsu: load/store unit between the MEM stage and a byte-addressed data memory.
//   Request side : req_valid/req_ready handshake with we, funct3, addr, wdata, rd tag.
//   Response side: resp_valid/resp_ready with extended load data, tag and fault flag.
//   Memory side  : dm_* driven for exactly one ACCESS cycle per legal request;
//                  dm_rdata is combinational and sampled on the edge ending ACCESS.
//   err_cnt      : saturating count of faulted (illegal/misaligned/out-of-range) requests.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// ACCESS | data memory port driven for one cycle
// RESP   | response held until resp_ready
module rvx_lsu #(
    parameter int BUS_W   = 32,
    parameter int DM_SIZE = 8192,
    parameter int ECNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [BUS_W-1:0]  req_addr,
    input  logic [BUS_W-1:0]  req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [BUS_W-1:0]  resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic [ECNT_W-1:0] err_cnt,
    output logic [BUS_W-1:0]  dm_addr,
    output logic              dm_we,
    output logic              dm_re,
    output logic [3:0]        dm_strb,
    output logic [BUS_W-1:0]  dm_wdata,
    input  logic [BUS_W-1:0]  dm_rdata
);

    localparam int AW = BUS_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t             state_q;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [BUS_W-1:0]   addr_q;
    logic [BUS_W-1:0]   wdata_q;
    logic [BUS_W-1:0]   resp_rdata_q;
    logic [4:0]         resp_rd_q;
    logic               resp_err_q;
    logic [ECNT_W-1:0]  err_cnt_q;
    logic [ECNT_W-1:0]  err_cnt_d;

    logic [2:0]         req_size;
    logic               req_illegal;
    logic               req_misal;
    logic [AW-1:0]      req_last;
    logic               req_oor;
    logic               req_fault;
    logic               in_access;
    logic [BUS_W-1:0]   ld_data;

    // Request decode works on the live request inputs so the fault is known at accept.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
    end

    assign req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1])
                       || (req_we && req_funct3[2]);
    assign req_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                       || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // One extra bit so an access near the top of the address space cannot wrap to 0.
    assign req_last    = {1'b0, req_addr} + AW'(req_size) - AW'(1);
    assign req_oor     = req_last >= AW'(DM_SIZE);
    assign req_fault   = req_illegal || req_misal || req_oor;

    assign err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

    always_comb begin
        case (f3_q)
            3'b000:  ld_data = {{(BUS_W-8){dm_rdata[7]}}, dm_rdata[7:0]};
            3'b100:  ld_data = {{(BUS_W-8){1'b0}}, dm_rdata[7:0]};
            3'b001:  ld_data = {{(BUS_W-16){dm_rdata[15]}}, dm_rdata[15:0]};
            3'b101:  ld_data = {{(BUS_W-16){1'b0}}, dm_rdata[15:0]};
            3'b010:  ld_data = dm_rdata;
            default: ld_data = '0;
        endcase
    end

    // Memory port decoded from state so reset drops dm_we before the edge.
    assign in_access = (state_q == S_ACCESS);
    assign dm_we     = in_access && we_q;
    assign dm_re     = in_access && !we_q;
    assign dm_addr   = in_access ? addr_q : '0;
    assign dm_wdata  = (in_access && we_q) ? wdata_q : '0;

    always_comb begin
        dm_strb = 4'b0000;
        if (in_access) begin
            case (f3_q[1:0])
                2'b00:   dm_strb = 4'b0001;
                2'b01:   dm_strb = 4'b0011;
                default: dm_strb = 4'b1111;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;
    assign err_cnt    = err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        resp_rd_q <= req_rd;
                        if (req_fault) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            err_cnt_q    <= err_cnt_d;
                            state_q      <= S_RESP;
                        end else begin
                            resp_err_q <= 1'b0;
                            state_q    <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    resp_rdata_q <= we_q ? '0 : ld_data;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_err_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvx_lsu.sv
module tb_rvx_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [15:0] err_cnt;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic        dm_re;
    logic [3:0]  dm_strb;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0] mem [0:8191];

    int we_cycles   = 0;
    int re_cycles   = 0;
    int strbf_cycles = 0;

    rvx_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .err_cnt    (err_cnt),
        .dm_addr    (dm_addr),
        .dm_we      (dm_we),
        .dm_re      (dm_re),
        .dm_strb    (dm_strb),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: combinational read, byte-strobed write on the rising edge.
    always_comb begin
        dm_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (dm_addr < 32'(8192 - i))
                dm_rdata[8*i +: 8] = mem[dm_addr + 32'(i)];
        end
    end

    always @(posedge clk) begin
        if (dm_we) begin
            for (int i = 0; i < 4; i++) begin
                if (dm_strb[i] && (dm_addr < 32'(8192 - i)))
                    mem[dm_addr + 32'(i)] <= dm_wdata[8*i +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (dm_we === 1'b1) we_cycles++;
        if (dm_re === 1'b1) re_cycles++;
        if (dm_strb === 4'b1111) strbf_cycles++;
    end

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        exp_t got_e;
        int   lat;
        int   exp_lat;
        bit   got;
        e.rdata = exp_rdata;
        e.rd    = rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready_idle addr=%h got=%b want=1", addr, req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                lat = n;
            end
        end
        got_e = sb_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL resp_timeout addr=%h got=no response want=response", addr);
        end else begin
            exp_lat = got_e.err ? 1 : 2;
            if (lat != exp_lat) begin
                bad++;
                $display("FAIL latency addr=%h got=%0d want=%0d", addr, lat, exp_lat);
            end
            total++;
            if (resp_rdata !== got_e.rdata) begin
                bad++;
                $display("FAIL rdata addr=%h f3=%b got=%h want=%h", addr, f3, resp_rdata, got_e.rdata);
            end
            total++;
            if (resp_rd !== got_e.rd) begin
                bad++;
                $display("FAIL resp_rd addr=%h got=%0d want=%0d", addr, resp_rd, got_e.rd);
            end
            total++;
            if (resp_err !== got_e.err) begin
                bad++;
                $display("FAIL resp_err addr=%h got=%b want=%b", addr, resp_err, got_e.err);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'hFFFF_FFFF;
        req_rd     = 5'd3;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({resp_valid, resp_err, dm_we, dm_re} !== 4'b0000 || dm_strb !== 4'b0
            || dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_dm got=%b%b%b%b strb=%b addr=%h want=0", resp_valid, resp_err,
                     dm_we, dm_re, dm_strb, dm_addr);
        end
        total++;
        if (resp_rdata !== 32'h0 || resp_rd !== 5'd0 || err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_resp got rdata=%h rd=%0d cnt=%0d want=0", resp_rdata, resp_rd, err_cnt);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got ready=%b valid=%b want ready=1 valid=0", req_ready, resp_valid);
        end
    endtask

    task automatic test_word();
        int we0;
        int st0;
        we0 = we_cycles;
        st0 = strbf_cycles;
        run_req(1'b1, 3'b010, 32'h10, 32'h8899_AABB, 5'd1, 32'h0, 1'b0);
        total++;
        if (we_cycles - we0 != 1 || strbf_cycles - st0 != 1) begin
            bad++;
            $display("FAIL sw_one_cycle got we=%0d strbf=%0d want 1/1", we_cycles - we0, strbf_cycles - st0);
        end
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd2,  32'h8899_AABB, 1'b0);
        total++;
        if (strbf_cycles - st0 != 2) begin
            bad++;
            $display("FAIL lw_strb got=%0d want=2", strbf_cycles - st0);
        end
        run_req(1'b0, 3'b001, 32'h10, 32'h0, 5'd3,  32'hFFFF_AABB, 1'b0);
        run_req(1'b0, 3'b101, 32'h10, 32'h0, 5'd4,  32'h0000_AABB, 1'b0);
        run_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd5,  32'hFFFF_FF88, 1'b0);
    endtask

    task automatic test_byte();
        run_req(1'b1, 3'b000, 32'h21, 32'h0000_00F0, 5'd6, 32'h0, 1'b0);
        run_req(1'b0, 3'b000, 32'h21, 32'h0, 5'd7, 32'hFFFF_FFF0, 1'b0);
        run_req(1'b0, 3'b100, 32'h21, 32'h0, 5'd8, 32'h0000_00F0, 1'b0);
        run_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd9, 32'h0000_F000, 1'b0);
        total++;
        if (mem[32'h20] !== 8'h00 || mem[32'h22] !== 8'h00) begin
            bad++;
            $display("FAIL sb_neighbours got=%h/%h want=00/00", mem[32'h20], mem[32'h22]);
        end
    endtask

    task automatic test_misaligned();
        int we0;
        int re0;
        we0 = we_cycles;
        re0 = re_cycles;
        total++;
        if (err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL err_cnt_start got=%0d want=0", err_cnt);
        end
        run_req(1'b0, 3'b001, 32'h23, 32'h0, 5'd10, 32'h0, 1'b1);
        run_req(1'b0, 3'b010, 32'h22, 32'h0, 5'd11, 32'h0, 1'b1);
        total++;
        if (we_cycles != we0 || re_cycles != re0) begin
            bad++;
            $display("FAIL misal_no_access got we=%0d re=%0d want 0/0", we_cycles - we0, re_cycles - re0);
        end
        total++;
        if (err_cnt !== 16'd2) begin
            bad++;
            $display("FAIL err_cnt_misal got=%0d want=2", err_cnt);
        end
    endtask

    task automatic test_range();
        int we0;
        run_req(1'b1, 3'b010, 32'h1FFC, 32'h1234_5678, 5'd12, 32'h0, 1'b0);
        run_req(1'b0, 3'b010, 32'h1FFC, 32'h0, 5'd13, 32'h1234_5678, 1'b0);
        run_req(1'b0, 3'b000, 32'h1FFF, 32'h0, 5'd14, 32'h0000_0012, 1'b0);
        run_req(1'b0, 3'b001, 32'h1FFE, 32'h0, 5'd15, 32'h0000_1234, 1'b0);
        we0 = we_cycles;
        run_req(1'b0, 3'b010, 32'h1FFE, 32'h0, 5'd16, 32'h0, 1'b1);
        run_req(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd17, 32'h0, 1'b1);
        run_req(1'b1, 3'b100, 32'h50, 32'h0000_00AA, 5'd18, 32'h0, 1'b1);
        run_req(1'b0, 3'b001, 32'h2000, 32'h0, 5'd19, 32'h0, 1'b1);
        run_req(1'b0, 3'b011, 32'h30, 32'h0, 5'd20, 32'h0, 1'b1);
        total++;
        if (we_cycles != we0) begin
            bad++;
            $display("FAIL fault_no_write got=%0d want=0", we_cycles - we0);
        end
        total++;
        if (err_cnt !== 16'd7) begin
            bad++;
            $display("FAIL err_cnt_range got=%0d want=7", err_cnt);
        end
        run_req(1'b0, 3'b010, 32'h50, 32'h0, 5'd21, 32'h0, 1'b0);
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   got;
        e.rdata = 32'h8899_AABB;
        e.rd    = 5'd22;
        e.err   = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_rd     = 5'd22;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bp_timeout got=no response want=response");
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== sb_q[0].rdata
                || resp_rd !== sb_q[0].rd || resp_err !== sb_q[0].err) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got v=%b r=%b d=%h want v=1 r=0 d=%h",
                         k, resp_valid, req_ready, resp_rdata, sb_q[0].rdata);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        e = sb_q.pop_front();
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got v=%b r=%b want v=0 r=1", resp_valid, req_ready);
        end
        total++;
        if (resp_rdata !== e.rdata || resp_rd !== e.rd) begin
            bad++;
            $display("FAIL bp_keep got d=%h rd=%0d want d=%h rd=%0d", resp_rdata, resp_rd, e.rdata, e.rd);
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'hDEAD_BEEF;
        req_rd     = 5'd23;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        total++;
        if (dm_we !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_access got dm_we=%b want=1", dm_we);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (dm_we !== 1'b0 || dm_re !== 1'b0 || dm_strb !== 4'b0 || dm_addr !== 32'h0
            || dm_wdata !== 32'h0 || resp_valid !== 1'b0 || err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL abort_outputs got we=%b strb=%b addr=%h v=%b cnt=%0d want 0",
                     dm_we, dm_strb, dm_addr, resp_valid, err_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_no_resp got=response want=none");
        end
        run_req(1'b0, 3'b010, 32'h40, 32'h0, 5'd24, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        test_reset();
        test_word();
        test_byte();
        test_misaligned();
        test_range();
        test_backpressure();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
